// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-request memory.
// Serves one transaction at a time. The memory-side request is registered, the
// completion pulse goes back to the client combinationally, and every
// transaction is followed by one quiet cycle before the next grant.
module mem_arbiter #(
    parameter bit FAIR = 1'b1   // 1: round-robin on contention, 0: data port always wins
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic        i_resp,
    output logic [15:0] i_rdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [1:0]  d_byte_enable,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    output logic        d_resp,
    output logic [15:0] d_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned BEW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_d_q, grant_d_d;   // port owning the transaction: 1 = data, 0 = instruction
    logic             last_d_q, last_d_d;     // last-served port: 1 = data, 0 = instruction
    logic             mem_read_d, mem_write_d;
    logic [BEW-1:0]   mem_byte_enable_d;
    logic [AW-1:0]    mem_address_d;
    logic [DW-1:0]    mem_wdata_d;
    logic             d_req;
    logic             pick_d;

    // Request decode and arbitration winner
    assign d_req  = d_read | d_write;
    assign pick_d = d_req & (~i_read | ~FAIR | ~last_d_q);

    // Read data fans out to both clients; each qualifies it with its own resp
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // State, grant bookkeeping and memory request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_d_q       <= 1'b0;
            last_d_q        <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
        end else begin
            state_q         <= state_d;
            grant_d_q       <= grant_d_d;
            last_d_q        <= last_d_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            mem_byte_enable <= mem_byte_enable_d;
            mem_address     <= mem_address_d;
            mem_wdata       <= mem_wdata_d;
        end
    end

    // Next state, grant latch and combinational completion pulses
    always_comb begin
        state_d           = state_q;
        grant_d_d         = grant_d_q;
        last_d_d          = last_d_q;
        mem_read_d        = mem_read;
        mem_write_d       = mem_write;
        mem_byte_enable_d = mem_byte_enable;
        mem_address_d     = mem_address;
        mem_wdata_d       = mem_wdata;
        i_resp            = 1'b0;
        d_resp            = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_read | d_req) begin
                    state_d   = BUSY;
                    grant_d_d = pick_d;
                    last_d_d  = pick_d;
                    if (pick_d) begin
                        mem_write_d       = d_write;
                        mem_read_d        = d_read & ~d_write;
                        mem_byte_enable_d = d_byte_enable;
                        mem_address_d     = d_address;
                        mem_wdata_d       = d_wdata;
                    end else begin
                        mem_write_d       = 1'b0;
                        mem_read_d        = 1'b1;
                        mem_byte_enable_d = BEW'(2'b11);
                        mem_address_d     = i_address;
                        mem_wdata_d       = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    i_resp      = ~grant_d_q;
                    d_resp      = grant_d_q;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning: 1 = round-robin on contention, 0 = fixed data-port priority.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 i_read  in  1  instruction-port read request, held until i_resp.
REQ-006 i_address  in  16  instruction-port byte address.
REQ-007 i_resp  out  1  instruction-port completion pulse.
REQ-008 i_rdata  out  16  instruction-port read data.
REQ-009 d_read  in  1  data-port read request, held until d_resp.
REQ-010 d_write  in  1  data-port write request, held until d_resp.
REQ-011 d_byte_enable  in  2  data-port byte lane enables; [1] is the high byte.
REQ-012 d_address  in  16  data-port byte address.
REQ-013 d_wdata  in  16  data-port write data.
REQ-014 d_resp  out  1  data-port completion pulse.
REQ-015 d_rdata  out  16  data-port read data.
REQ-016 mem_read, mem_write  out  1 each  memory requests, registered.
REQ-017 mem_byte_enable  out  2  memory lane enables, registered.
REQ-018 mem_address, mem_wdata  out  16 each  memory address and write data, registered.
REQ-019 mem_resp  in  1  memory completion; one-cycle pulse.
REQ-020 mem_rdata  in  16  memory read data; valid while mem_resp is high.

Function
REQ-021 The block SHALL implement three states: IDLE, BUSY, DONE.
REQ-022 In IDLE with no request pending, the block SHALL remain in IDLE with mem_read=mem_write=0.
REQ-023 In IDLE with any request pending, the block SHALL grant one port, latch that port's operation, address, byte enables and wdata into the mem_* registers, and go to BUSY on the next edge.
REQ-024 Instruction grant: mem_read=1, mem_write=0, mem_byte_enable=2'b11, mem_address=i_address, mem_wdata=0.
REQ-025 Data grant: mem_write=d_write, mem_read=d_read&~d_write (d_write wins if both are high); mem_byte_enable, mem_address and mem_wdata come from the d_* inputs.
REQ-026 Contention with FAIR=0: data SHALL win.
REQ-027 Contention with FAIR=1: the port not served last SHALL win; the last-served pointer initialises to "instruction", so data wins the first tie.
REQ-028 The last-served pointer SHALL update on every grant, contended or not.
REQ-029 In BUSY, the mem_* registers SHALL hold constant and client inputs SHALL be ignored.
REQ-030 In BUSY, when mem_resp=1, the granted port's resp SHALL equal 1 in that same cycle (combinational, zero added latency); the other port's resp SHALL be 0.
REQ-031 On that same edge, mem_read and mem_write SHALL clear and the state SHALL go to DONE.
REQ-032 i_rdata and d_rdata SHALL both equal mem_rdata at all times; each is meaningful only while its resp is high.
REQ-033 DONE SHALL last exactly one cycle, with mem_read=mem_write=0 and no client requests sampled; it SHALL then go to IDLE. This lets the served client drop its request and gives memory an idle cycle.
REQ-034 Back-to-back throughput: mem_resp at cycle R gives DONE at R+1, IDLE sampling at R+2, and the next mem request asserted at R+3.
REQ-035 If a client deasserts its request while in BUSY, the latched transaction SHALL still complete and resp SHALL still pulse to that port.
REQ-036 mem_resp outside BUSY SHALL be ignored: no client resp, no state change.
REQ-037 i_resp and d_resp SHALL never both be high.

Reset
REQ-038 When rst is asserted, asynchronously and at any state including mid-BUSY, the block SHALL: go to IDLE; clear mem_read, mem_write, mem_byte_enable, mem_address and mem_wdata to 0; drive i_resp=d_resp=0; reset the last-served pointer to "instruction".
REQ-039 An in-flight transaction aborted by reset SHALL produce no client resp.

Verification
REQ-040 Single fetch: i_read=1, i_address=16'h0040, mem_resp 3 cycles after mem_read -> mem_read high from cycle 1 with address 16'h0040 and byte_enable 2'b11; i_resp pulses 1 cycle; i_rdata=mem_rdata.
REQ-041 Data write: d_write=1, d_byte_enable=2'b01, d_address=16'h1235, d_wdata=16'hBEEF -> mem_write=1, mem_byte_enable=2'b01, mem_address=16'h1235, mem_wdata=16'hBEEF; d_resp pulses once; mem_read=0 throughout.
REQ-042 Contention with FAIR=1: both ports request continuously from reset -> grant order D, I, D, I; each mem request starts exactly 3 cycles after the previous mem_resp.
REQ-043 Contention with FAIR=0: both ports request continuously -> data served every time; i_resp never pulses.
REQ-044 Reset during BUSY: assert rst with mem_read=1 -> mem_read=0 immediately; no resp on either port; after release, the first tie is granted to data.
REQ-045 Stray and drop: mem_resp pulse in IDLE -> no resp, no state change; d_read dropped mid-BUSY -> d_resp still pulses on mem_resp.
